// File: rtl/pkt_attr_sequencer.sv
// Packet-type decoder for the baseband TX path: latches payload attributes at the
// first encode slot, then tracks payload bits and slot occupancy until the packet ends.
module pkt_attr_sequencer #(
    parameter int LEN_W     = 10,
    parameter int PYLEN_W   = LEN_W + 3,
    parameter int SLOT_W    = 3,
    parameter int MAX_SLOTS = 5
) (
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic [3:0]         pk_type,
    input  logic               is_BRmode,
    input  logic               is_eSCO,
    input  logic               is_SCO,
    input  logic               pktype_data,
    input  logic [LEN_W-1:0]   regi_payloadlen,
    input  logic               pk_encode_1stslot,
    input  logic               ms_tslot_p,
    input  logic               bit_en,
    input  logic               abort,
    output logic [PYLEN_W-1:0] pylenbit_q,
    output logic [SLOT_W-1:0]  occupy_slots_q,
    output logic               fec31_q,
    output logic               fec32_q,
    output logic               crc_q,
    output logic               brmode_q,
    output logic               dpsk_q,
    output logic               pyhdr_q,
    output logic               brss_q,
    output logic               busy,
    output logic [PYLEN_W-1:0] bits_left,
    output logic [SLOT_W-1:0]  slot_idx,
    output logic               extendslot,
    output logic               payload_done,
    output logic               len_err
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;

    localparam logic [SLOT_W-1:0] MAX_S = SLOT_W'(MAX_SLOTS);

    state_t              state_q, state_d;
    logic [PYLEN_W-1:0]  len_d, bytes_d, bits_d;
    logic [SLOT_W-1:0]   slots_d, slot_d, occ_next;
    logic                fec31_d, fec32_d, crc_d, br_d, dpsk_d, pyhdr_d;
    logic                latch, done_d, err_d, ext_d;
    int                  slot_raw;

    // Attribute decode
    always_comb begin
        bytes_d  = PYLEN_W'(regi_payloadlen) + PYLEN_W'(pktype_data);
        len_d    = bytes_d << 3;
        pyhdr_d  = 1'b1;
        fec31_d  = 1'b0;
        fec32_d  = 1'b1;
        crc_d    = 1'b1;
        br_d     = 1'b1;
        dpsk_d   = 1'b1;
        slot_raw = 1;
        case (pk_type)
            4'h0, 4'h1: begin
                len_d   = '0;
                pyhdr_d = 1'b0;
            end
            4'h2: begin
                len_d   = PYLEN_W'(144);
                pyhdr_d = 1'b0;
            end
            4'h4: begin
                fec32_d = 1'b0;
                br_d    = is_BRmode;
            end
            4'h5: begin
                len_d   = PYLEN_W'(80);
                fec31_d = 1'b1;
                crc_d   = 1'b0;
                pyhdr_d = 1'b0;
            end
            4'h6: begin
                pyhdr_d = 1'b0;
                if (is_eSCO) begin
                    br_d    = 1'b0;
                    fec32_d = 1'b0;
                end else begin
                    len_d = PYLEN_W'(160);
                    crc_d = 1'b0;
                end
            end
            4'h7: begin
                pyhdr_d = 1'b0;
                if (is_eSCO && is_BRmode) begin
                    fec32_d = 1'b0;
                end else if (is_eSCO) begin
                    crc_d  = 1'b0;
                    br_d   = 1'b0;
                    dpsk_d = 1'b0;
                end else begin
                    fec32_d = 1'b0;
                    crc_d   = 1'b0;
                    len_d   = PYLEN_W'(240);
                end
            end
            4'h8: begin
                if (is_SCO) begin
                    len_d = PYLEN_W'(80) + ((PYLEN_W'(regi_payloadlen) + PYLEN_W'(1)) << 3);
                end else begin
                    br_d    = 1'b0;
                    dpsk_d  = 1'b0;
                    fec32_d = 1'b0;
                end
            end
            4'h9: crc_d = 1'b0;
            4'ha: begin
                slot_raw = 3;
                br_d     = is_BRmode;
            end
            4'hb: begin
                slot_raw = 3;
                br_d     = is_BRmode;
                dpsk_d   = is_BRmode;
            end
            4'hc: begin
                slot_raw = 3;
                pyhdr_d  = 1'b0;
                br_d     = is_BRmode;
            end
            4'hd: begin
                slot_raw = 3;
                pyhdr_d  = 1'b0;
                br_d     = is_BRmode;
                dpsk_d   = is_BRmode;
            end
            4'he: begin
                slot_raw = 5;
                br_d     = is_BRmode;
            end
            4'hf: begin
                slot_raw = 5;
                br_d     = is_BRmode;
                dpsk_d   = is_BRmode;
            end
            default: ;
        endcase
        slots_d = (slot_raw > MAX_SLOTS) ? MAX_S : SLOT_W'(slot_raw);
    end

    // Sequencing: within a cycle the bit count is resolved before the slot boundary
    always_comb begin
        state_d = state_q;
        bits_d  = bits_left;
        slot_d  = slot_idx;
        latch   = 1'b0;
        done_d  = 1'b0;
        err_d   = len_err;
        case (state_q)
            IDLE: begin
                if (pk_encode_1stslot) begin
                    latch   = 1'b1;
                    bits_d  = len_d;
                    slot_d  = SLOT_W'(1);
                    err_d   = 1'b0;
                    state_d = (len_d != '0) ? PAYLOAD : HOLD;
                end
            end
            PAYLOAD: begin
                if (bit_en) begin
                    bits_d = bits_left - PYLEN_W'(1);
                    if (bits_left == PYLEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end
                end
                if (ms_tslot_p) begin
                    if (slot_idx < occupy_slots_q) begin
                        slot_d = slot_idx + SLOT_W'(1);
                    end else begin
                        state_d = IDLE;
                        if (!done_d) err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ms_tslot_p) begin
                    if (slot_idx < occupy_slots_q) slot_d = slot_idx + SLOT_W'(1);
                    else                           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            bits_d  = '0;
            slot_d  = '0;
            latch   = 1'b0;
            done_d  = 1'b0;
            err_d   = len_err;
        end
        occ_next = latch ? slots_d : occupy_slots_q;
        ext_d    = (state_d != IDLE) && (occ_next > SLOT_W'(1)) && (slot_d < occ_next);
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q        <= IDLE;
            pylenbit_q     <= '0;
            occupy_slots_q <= '0;
            fec31_q        <= 1'b0;
            fec32_q        <= 1'b0;
            crc_q          <= 1'b0;
            brmode_q       <= 1'b0;
            dpsk_q         <= 1'b0;
            pyhdr_q        <= 1'b0;
            bits_left      <= '0;
            slot_idx       <= '0;
            extendslot     <= 1'b0;
            payload_done   <= 1'b0;
            len_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bits_left    <= bits_d;
            slot_idx     <= slot_d;
            extendslot   <= ext_d;
            payload_done <= done_d;
            len_err      <= err_d;
            if (latch) begin
                pylenbit_q     <= len_d;
                occupy_slots_q <= slots_d;
                fec31_q        <= fec31_d;
                fec32_q        <= fec32_d;
                crc_q          <= crc_d;
                brmode_q       <= br_d;
                dpsk_q         <= dpsk_d;
                pyhdr_q        <= pyhdr_d;
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign brss_q = brmode_q & (occupy_slots_q == SLOT_W'(1));

endmodule

// File: tb/tb_pkt_attr_sequencer.sv
// Bench for pkt_attr_sequencer: default instance plus a MAX_SLOTS=3 instance on shared
// stimulus, each compared every cycle against a packet-level reference model.
module tb_pkt_attr_sequencer;

    localparam int unsigned LMASK = 32'h1fff;

    typedef struct packed {
        logic        busy, payload, done, err, f31, f32, crc, br, dpsk, hdr;
        int unsigned bits, slot, occ, len;
    } mdl_t;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b1;
    logic [3:0]  pk_type = '0;
    logic        is_BRmode = 1'b0, is_eSCO = 1'b0, is_SCO = 1'b0, pktype_data = 1'b0;
    logic [9:0]  regi_payloadlen = '0;
    logic        pk_encode_1stslot = 1'b0, ms_tslot_p = 1'b0, bit_en = 1'b0, abort = 1'b0;

    logic [12:0] pyl0, bl0, pyl1, bl1;
    logic [2:0]  occ0, si0, occ1, si1;
    logic        f31_0, f32_0, crc0, br0, dpsk0, hdr0, brss0, busy0, ext0, done0, err0;
    logic        f31_1, f32_1, crc1, br1, dpsk1, hdr1, brss1, busy1, ext1, done1, err1;

    int   n_checks = 0;
    int   n_fail   = 0;
    mdl_t m0, m1;

    always #5 clk_6M = ~clk_6M;

    pkt_attr_sequencer dut0 (
        .clk_6M(clk_6M), .rstz(rstz), .pk_type(pk_type), .is_BRmode(is_BRmode),
        .is_eSCO(is_eSCO), .is_SCO(is_SCO), .pktype_data(pktype_data),
        .regi_payloadlen(regi_payloadlen), .pk_encode_1stslot(pk_encode_1stslot),
        .ms_tslot_p(ms_tslot_p), .bit_en(bit_en), .abort(abort),
        .pylenbit_q(pyl0), .occupy_slots_q(occ0), .fec31_q(f31_0), .fec32_q(f32_0),
        .crc_q(crc0), .brmode_q(br0), .dpsk_q(dpsk0), .pyhdr_q(hdr0), .brss_q(brss0),
        .busy(busy0), .bits_left(bl0), .slot_idx(si0), .extendslot(ext0),
        .payload_done(done0), .len_err(err0)
    );

    pkt_attr_sequencer #(.MAX_SLOTS(3)) dut1 (
        .clk_6M(clk_6M), .rstz(rstz), .pk_type(pk_type), .is_BRmode(is_BRmode),
        .is_eSCO(is_eSCO), .is_SCO(is_SCO), .pktype_data(pktype_data),
        .regi_payloadlen(regi_payloadlen), .pk_encode_1stslot(pk_encode_1stslot),
        .ms_tslot_p(ms_tslot_p), .bit_en(bit_en), .abort(abort),
        .pylenbit_q(pyl1), .occupy_slots_q(occ1), .fec31_q(f31_1), .fec32_q(f32_1),
        .crc_q(crc1), .brmode_q(br1), .dpsk_q(dpsk1), .pyhdr_q(hdr1), .brss_q(brss1),
        .busy(busy1), .bits_left(bl1), .slot_idx(si1), .extendslot(ext1),
        .payload_done(done1), .len_err(err1)
    );

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Attribute table written as a base packet plus per-type overrides
    function automatic mdl_t decode(mdl_t m, int unsigned maxs);
        mdl_t n = m;
        int unsigned pt = pk_type;
        int unsigned slots;
        n.hdr = 1; n.f31 = 0; n.f32 = 1; n.crc = 1; n.br = 1; n.dpsk = 1;
        n.len = ((regi_payloadlen + pktype_data) * 8) & LMASK;
        slots = (pt >= 14) ? 5 : (pt >= 10) ? 3 : 1;
        if (pt >= 10) begin
            n.br = is_BRmode;
            if (pt % 2 == 1) n.dpsk = is_BRmode;
            if (pt == 12 || pt == 13) n.hdr = 0;
        end
        case (pt)
            0, 1: begin n.len = 0; n.hdr = 0; end
            2:    begin n.len = 144; n.hdr = 0; end
            4:    begin n.f32 = 0; n.br = is_BRmode; end
            5:    begin n.len = 80; n.f31 = 1; n.crc = 0; n.hdr = 0; end
            6:    begin
                n.hdr = 0;
                if (is_eSCO) begin n.br = 0; n.f32 = 0; end
                else begin n.len = 160; n.crc = 0; end
            end
            7:    begin
                n.hdr = 0;
                if (is_eSCO && is_BRmode) n.f32 = 0;
                else if (is_eSCO) begin n.crc = 0; n.br = 0; n.dpsk = 0; end
                else begin n.f32 = 0; n.crc = 0; n.len = 240; end
            end
            8:    begin
                if (is_SCO) n.len = (80 + (regi_payloadlen + 1) * 8) & LMASK;
                else begin n.br = 0; n.dpsk = 0; n.f32 = 0; end
            end
            9:    n.crc = 0;
            default: ;
        endcase
        n.occ = (slots > maxs) ? maxs : slots;
        return n;
    endfunction

    function automatic mdl_t step(mdl_t m, int unsigned maxs);
        mdl_t n = m;
        n.done = 0;
        if (abort) begin
            n.busy = 0; n.payload = 0; n.bits = 0; n.slot = 0;
        end else if (!m.busy) begin
            if (pk_encode_1stslot) begin
                n = decode(n, maxs);
                n.bits = n.len; n.slot = 1; n.busy = 1; n.err = 0;
                n.payload = (n.len != 0);
            end
        end else begin
            if (m.payload && bit_en) begin
                n.bits = m.bits - 1;
                if (n.bits == 0) begin n.done = 1; n.payload = 0; end
            end
            if (ms_tslot_p) begin
                if (m.slot < m.occ) n.slot = m.slot + 1;
                else begin
                    if (n.payload) n.err = 1;
                    n.busy = 0; n.payload = 0;
                end
            end
        end
        return n;
    endfunction

    task automatic cmp(input string p, input mdl_t m, input logic [12:0] pyl, input logic [2:0] occ,
                       input logic f31, input logic f32, input logic crc, input logic br,
                       input logic dpsk, input logic hdr, input logic brss, input logic bsy,
                       input logic [12:0] bl, input logic [2:0] si, input logic ext,
                       input logic dn, input logic er);
        chk({p, "pylen"}, pyl, m.len);
        chk({p, "occ"}, occ, m.occ);
        chk({p, "fec31"}, f31, m.f31);
        chk({p, "fec32"}, f32, m.f32);
        chk({p, "crc"}, crc, m.crc);
        chk({p, "br"}, br, m.br);
        chk({p, "dpsk"}, dpsk, m.dpsk);
        chk({p, "pyhdr"}, hdr, m.hdr);
        chk({p, "brss"}, brss, m.br && m.occ == 1);
        chk({p, "busy"}, bsy, m.busy);
        chk({p, "bits_left"}, bl, m.bits);
        chk({p, "slot_idx"}, si, m.slot);
        chk({p, "extslot"}, ext, m.busy && m.occ > 1 && m.slot < m.occ);
        chk({p, "done"}, dn, m.done);
        chk({p, "len_err"}, er, m.err);
    endtask

    task automatic cycle();
        @(posedge clk_6M);
        m0 = step(m0, 5);
        m1 = step(m1, 3);
        #1;
        cmp("d0_", m0, pyl0, occ0, f31_0, f32_0, crc0, br0, dpsk0, hdr0, brss0, busy0, bl0, si0, ext0, done0, err0);
        cmp("d1_", m1, pyl1, occ1, f31_1, f32_1, crc1, br1, dpsk1, hdr1, brss1, busy1, bl1, si1, ext1, done1, err1);
    endtask

    task automatic drive(input logic s, input logic b, input logic t, input logic a);
        pk_encode_1stslot = s; bit_en = b; ms_tslot_p = t; abort = a;
        cycle();
    endtask

    task automatic setup(input int unsigned pt, input int unsigned len, input logic d,
                         input logic brm, input logic esco, input logic sco);
        pk_type = 4'(pt); regi_payloadlen = 10'(len); pktype_data = d;
        is_BRmode = brm; is_eSCO = esco; is_SCO = sco;
    endtask

    initial begin
        m0 = '0;
        m1 = '0;
        #1 rstz = 1'b0;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_pylen", pyl0, 0);
        chk("rst_fec32", f32_0, 0);
        chk("rst_occ", occ1, 0);
        @(negedge clk_6M);
        @(negedge clk_6M);
        rstz = 1'b1;
        #1;
        drive(0, 0, 0, 0);

        // DM1 with data header byte
        setup(3, 10, 1, 1, 0, 0);
        drive(1, 0, 0, 0);
        chk("t3_pylen", pyl0, 88);
        chk("t3_fec32", f32_0, 1);
        chk("t3_brss", brss0, 1);
        for (int i = 0; i < 88; i++) drive(0, 1, 0, 0);
        chk("t3_done", done0, 1);
        chk("t3_bits", bl0, 0);
        drive(0, 0, 1, 0);
        chk("t3_busy", busy0, 0);
        chk("t3_err", err0, 0);

        // 5-slot packet, EDR; the MAX_SLOTS=3 instance overruns on the same stimulus
        setup(15, 20, 0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("tf_occ", occ0, 5);
        chk("tf_br", br0, 0);
        chk("tf_dpsk", dpsk0, 0);
        chk("tf_ext0", ext0, 1);
        chk("tf_occ_m3", occ1, 3);
        for (int i = 0; i < 200; i++) begin
            drive(0, i < 160, (i % 40) == 39, 0);
            if ((i % 40) == 39) begin
                chk("tf_ext", ext0, (i / 40) < 3);
                if (i == 119) chk("tf_m3_err", err1, 1);
            end
        end
        chk("tf_busy", busy0, 0);
        chk("tf_err", err0, 0);

        // Zero-length 5-slot type; MAX_SLOTS=3 instance finishes two pulses early
        setup(14, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 0);
            if (k == 3) begin
                chk("te_m3_busy", busy1, 0);
                chk("te_busy", busy0, 1);
            end
        end
        chk("te_end", busy0, 0);

        // 3-slot overrun: 800 bits, 500 consumed
        setup(10, 100, 0, 1, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) drive(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 0);
        end
        chk("ta_err", err0, 1);
        chk("ta_busy", busy0, 0);
        chk("ta_bits", bl0, 300);

        // NULL packet, then a strobe while busy
        setup(0, 7, 1, 1, 0, 0);
        drive(1, 0, 0, 0);
        chk("t0_pylen", pyl0, 0);
        chk("t0_hdr", hdr0, 0);
        chk("t0_err_clr", err0, 0);
        setup(3, 10, 1, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("t0_ignore", pyl0, 0);
        chk("t0_nodone", done0, 0);
        drive(0, 0, 1, 0);
        chk("t0_idle", busy0, 0);

        // SCO abort, then abort colliding with a strobe
        setup(8, 9, 0, 1, 0, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        chk("t8_pylen", pyl0, 160);
        chk("t8_busy", busy0, 0);
        chk("t8_bits", bl0, 0);
        setup(3, 10, 1, 1, 0, 0);
        drive(1, 0, 0, 1);
        chk("t8_nolatch", pyl0, 160);
        chk("t8_nobusy", busy0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            setup($urandom_range(0, 15), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023)
                                                                      : $urandom_range(0, 40),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
        end

        // Asynchronous reset in the middle of a packet
        setup(11, 30, 0, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        #2 rstz = 1'b0;
        #1;
        chk("ar_busy", busy0, 0);
        chk("ar_pylen", pyl0, 0);
        chk("ar_occ", occ0, 0);
        chk("ar_bits", bl0, 0);
        chk("ar_slot", si0, 0);
        chk("ar_ext", ext0, 0);
        m0 = '0;
        m1 = '0;
        @(negedge clk_6M);
        rstz = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_attr_sequencer.md
Name: pkt_attr_sequencer

Overview:
- Next-generation packet-type decoder for the baseband TX path.
- Decodes pk_type/mode into payload attributes and latches them at the first encode slot, so attributes stay stable for the whole packet.
- Tracks consumed payload bits and the multi-slot window, flagging payload overrun.
- Generalised over payload-length width and maximum slot count; sits between the LMP/register block and the FEC/CRC/whitening encoder.

Parameters:
LEN_W, 10, width of regi_payloadlen in bytes
PYLEN_W, LEN_W+3, width of the payload bit length
SLOT_W, 3, width of slot counters
MAX_SLOTS, 5, clamp on decoded occupied slots; must be ≥1 and <2^SLOT_W

Ports:
clk_6M  in  1  system clock
rstz  in  1  reset
pk_type  in  4  packet type code
is_BRmode, is_eSCO, is_SCO  in  1 each  link mode qualifiers
pktype_data  in  1  payload carries a 1-byte data header adjust (+1 byte)
regi_payloadlen  in  LEN_W  payload length in bytes
pk_encode_1stslot  in  1  latch strobe, start of packet
ms_tslot_p  in  1  slot-boundary pulse
bit_en  in  1  encoder consumed one payload bit
abort  in  1  synchronous cancel
pylenbit_q  out  PYLEN_W  latched payload bits
occupy_slots_q  out  SLOT_W  latched slot count
fec31_q, fec32_q, crc_q, brmode_q, dpsk_q, pyhdr_q  out  1 each  latched encode attributes
brss_q  out  1  brmode_q & (occupy_slots_q==1)
busy  out  1  packet in progress
bits_left  out  PYLEN_W  remaining payload bits
slot_idx  out  SLOT_W  current slot of packet, 1-based
extendslot  out  1  inside a multi-slot packet, before its last slot
payload_done  out  1  single-cycle pulse, last payload bit consumed
len_err  out  1  sticky overrun flag

Reset: rstz, asynchronous, active-low; clock clk_6M.

Behaviour:
- All outputs reset to 0; FSM resets to IDLE.
- Decode (combinational, then latched):
  - Default: pyhdr=1, fec31=0, fec32=1, crc=1, br=1, dpsk=1, slots=1, len=(payloadlen+pktype_data)*8.
  - 0/1: len=0, pyhdr=0.
  - 2: len=144, pyhdr=0.
  - 4: fec32=0, br=is_BRmode.
  - 5: len=80, fec31=1, crc=0, pyhdr=0.
  - 6 eSCO: br=0, fec32=0, pyhdr=0. 6 else: len=160, crc=0, pyhdr=0.
  - 7 eSCO&BR: fec32=0, pyhdr=0. 7 eSCO&!BR: crc=0, br=0, dpsk=0, pyhdr=0. 7 else: fec32=0, crc=0, len=240, pyhdr=0.
  - 8 SCO: len=80+(payloadlen+1)*8. 8 else: br=0, dpsk=0, fec32=0.
  - 9: crc=0.
  - a: slots=3, br=is_BRmode.
  - b: slots=3, br=dpsk=is_BRmode.
  - c: slots=3, pyhdr=0, br=is_BRmode.
  - d: slots=3, pyhdr=0, br=dpsk=is_BRmode.
  - e: slots=5, br=is_BRmode.
  - f: slots=5, br=dpsk=is_BRmode.
- Arithmetic: len arithmetic is modulo 2^PYLEN_W (truncate). Decoded slots are clamped to MAX_SLOTS.
- FSM states: IDLE, PAYLOAD, HOLD.
- IDLE:
  - On pk_encode_1stslot, latch all attributes, set bits_left=len, slot_idx=1, busy=1, clear len_err.
  - Next state is PAYLOAD if len≠0, else HOLD (no payload_done for zero length).
- PAYLOAD:
  - Each bit_en decrements bits_left.
  - bit_en with bits_left==1: bits_left=0, payload_done=1 for that cycle, go HOLD.
- PAYLOAD/HOLD slot tracking: ms_tslot_p with slot_idx<occupy_slots_q increments slot_idx.
- Last slot (ms_tslot_p with slot_idx==occupy_slots_q):
  - In HOLD: go IDLE, busy=0.
  - In PAYLOAD: overrun; set len_err=1, go IDLE. Latched attributes hold until the next latch.
- Simultaneous bit_en (last bit) and final ms_tslot_p: bit counts first; payload_done=1, no len_err, go IDLE.
- bit_en in IDLE or HOLD: ignored.
- pk_encode_1stslot while busy: ignored.
- extendslot = busy & (occupy_slots_q>1) & (slot_idx<occupy_slots_q), registered with the state.
- abort (any state): go IDLE, busy=0, bits_left=0, slot_idx=0. Latched attributes and len_err are kept.
- abort together with pk_encode_1stslot: abort wins; no latch.
- Latency: attributes visible the cycle after the strobe. payload_done is asserted in the cycle after the final bit_en sample.
- Mid-packet async reset: everything returns to reset values immediately.

Test Plan:
- Type 3 (DM1), payloadlen=10, pktype_data=1, BR: strobe → pylenbit_q=88, fec32_q=1, brss_q=1. 88 bit_en → payload_done on the 88th; next ms_tslot_p → busy=0, len_err=0.
- Type f, is_BRmode=0, len=20: occupy_slots_q=5, brmode_q=0, dpsk_q=0, extendslot=1 for slot_idx 1–4. Deassert on the ms_tslot_p moving to slot 5; IDLE after the 5th boundary pulse.
- MAX_SLOTS=3, type e: occupy_slots_q=3; packet ends after 3 slot pulses.
- Type a, len=100 (800 bits), only 500 bit_en before the 3rd slot pulse → len_err=1, busy=0, bits_left stays at 300.
- Type 0 (NULL): pylenbit_q=0, pyhdr_q=0, HOLD immediately, no payload_done; one ms_tslot_p → IDLE. Second strobe while busy is ignored.
- abort mid-PAYLOAD of type 8 SCO, len=9: pylenbit_q=160 retained; busy=0, bits_left=0. abort and strobe in the same cycle → no latch.
